multdiv_engine: RTL and testbench
=================================

MULTDIV_ENGINE -- requirements
Module: multdiv_engine

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, execute stage requests a multiply/divide; held high until ok seen.
REQ-004 SHALL have port multicycle_type, input, multicycle_t, operation: M_MULT, M_MULTU, M_DIV, M_DIVU; M_MADD/M_MSUB treated as M_MULT.
REQ-005 SHALL have port a, input, 32, operand rs (dividend / multiplicand).
REQ-006 SHALL have port b, input, 32, operand rt (divisor / multiplier).
REQ-007 SHALL have port flush, input, 1, abort any operation in progress.
REQ-008 SHALL have port hi, output, 32, high product word / remainder.
REQ-009 SHALL have port lo, output, 32, low product word / quotient.
REQ-010 SHALL have port ok, output, 1, result available / no stall needed.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-012 IDLE with start=1 and flush=0 SHALL latch a, b and the operation, clear a 5-bit counter, and go to BUSY.
REQ-013 IDLE with start=0 SHALL stay in IDLE.
REQ-014 BUSY SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; always 32 steps.
REQ-015 Signed operations SHALL iterate on operand magnitudes and apply the sign correction when leaving BUSY.
REQ-016 Sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
REQ-017 After step 32, the FSM SHALL register the corrected hi/lo and go to DONE.
REQ-018 DONE SHALL go to IDLE unconditionally, even with start still high, so a held start never restarts the same instruction.
REQ-019 ok SHALL be combinational: 1 in DONE, 1 in IDLE when start=0, 0 otherwise.
REQ-020 Latency SHALL be fixed: start accepted in cycle 0, BUSY in cycles 1-32, DONE (ok=1, hi/lo valid) in cycle 33.
REQ-021 hi/lo SHALL change only on entry to DONE and SHALL hold between operations.
REQ-022 Back-to-back: start high in the cycle after DONE SHALL be accepted as a new operation.
REQ-023 Divide by zero SHALL give lo=0xFFFFFFFF and hi=a, with no sign correction, signed or unsigned; no exception.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge and leave hi/lo unchanged; flush wins over a simultaneous start.
REQ-025 Multiply SHALL produce the full 64-bit result in {hi,lo}; no truncation or overflow flag.

Reset
REQ-026 reset=1 SHALL force IDLE, hi=0, lo=0 and counter=0 at the next edge, including mid-operation.
REQ-027 During and right after reset, ok SHALL equal ~start per REQ-019.

Structure
REQ-028 multicycle_t enum and the constant MD_STEPS=32 SHALL live in the shared common package.
REQ-029 Sign handling, the FSM and the counter SHALL be in multdiv_engine.
REQ-030 The unsigned 32-step shift-add/shift-subtract datapath SHALL be one sub-module, md_iter_core.

Verification
REQ-031 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> ok=0 for cycles 0-32; ok=1 in cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-034 DIVU 100/7 started, flush at cycle 10 -> IDLE at cycle 11, hi/lo keep previous values; restart completes with lo=14, hi=2.
REQ-035 Start held through DONE, then a second MULTU 3*4 -> exactly one result per instruction; second gives hi=0, lo=12.
REQ-036 reset asserted at cycle 20 of a DIV -> hi=lo=0, IDLE next cycle; ok follows ~start.

Source files
------------

// File: rtl/multdiv_engine_pkg.sv
// ============================================================================
// Module : multdiv_engine_pkg
// Brief  : Shared operation encoding, FSM states and helpers for multdiv_engine
// Rev    : 1.0
// ============================================================================
`default_nettype none

package multdiv_engine_pkg;

    localparam int MD_STEPS = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [2:0] {
        M_MULT  = 3'd0,
        M_MULTU = 3'd1,
        M_DIV   = 3'd2,
        M_DIVU  = 3'd3,
        M_MADD  = 3'd4,
        M_MSUB  = 3'd5
    } multicycle_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Two's-complement magnitude; unsigned operands pass through untouched.
    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_engine_if.sv
// ============================================================================
// Module : multdiv_engine_if
// Brief  : Execute-stage request/result bundle for the multiply/divide engine
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface multdiv_engine_if;
    import multdiv_engine_pkg::*;

    logic        start;
    multicycle_t multicycle_type;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ok;

    modport master (
        output start, multicycle_type, a, b, flush,
        input  hi, lo, ok
    );

    modport slave (
        input  start, multicycle_type, a, b, flush,
        output hi, lo, ok
    );

endinterface

`default_nettype wire

// File: rtl/md_iter_core.sv
// ============================================================================
// Module : md_iter_core
// Brief  : Unsigned radix-2 shift-add multiply / restoring divide datapath
// Rev    : 1.0
// ============================================================================
`default_nettype none

module md_iter_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [31:0] i_init,
    input  logic [31:0] i_opnd,
    output logic [31:0] o_hi_nxt,
    output logic [31:0] o_lo_nxt
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;
    logic        r_is_div;

    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic [31:0] w_diff;
    logic        w_ge;

    // Partial remainder needs 33 bits after the shift; the difference always
    // fits in 32 bits whenever the subtraction is kept.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
        w_rem_sh = {r_hi, r_lo[31]};
        w_ge     = (w_rem_sh >= {1'b0, r_opnd});
        w_diff   = w_rem_sh[31:0] - r_opnd;
        if (r_is_div) begin
            o_hi_nxt = w_ge ? w_diff : w_rem_sh[31:0];
            o_lo_nxt = {r_lo[30:0], w_ge};
        end else begin
            o_hi_nxt = w_sum[32:1];
            o_lo_nxt = {w_sum[0], r_lo[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_opnd   <= 32'd0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_hi     <= 32'd0;
            r_lo     <= i_init;
            r_opnd   <= i_opnd;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_hi     <= o_hi_nxt;
            r_lo     <= o_lo_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multdiv_engine.sv
// ============================================================================
// Module : multdiv_engine
// Brief  : 33-cycle fixed-latency MIPS-style multiply/divide unit with flush
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multdiv_engine
    import multdiv_engine_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multdiv_engine_if.slave   bus
);

    localparam logic [MD_CNT_W-1:0] C_LAST_STEP = MD_CNT_W'(MD_STEPS - 1);

    md_state_t             r_state;
    logic [MD_CNT_W-1:0]   r_cnt;
    logic [31:0]           r_hi;
    logic [31:0]           r_lo;
    logic [31:0]           r_a;
    logic                  r_is_div;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_b_zero;

    logic                  w_is_div;
    logic                  w_is_signed;
    logic [31:0]           w_a_mag;
    logic [31:0]           w_b_mag;
    logic                  w_accept;
    logic [31:0]           w_core_hi;
    logic [31:0]           w_core_lo;
    logic [63:0]           w_prod;
    logic [31:0]           w_res_hi;
    logic [31:0]           w_res_lo;

    // MADD/MSUB and any unused code fall back to the multiply paths.
    assign w_is_div    = (bus.multicycle_type == M_DIV) || (bus.multicycle_type == M_DIVU);
    assign w_is_signed = (bus.multicycle_type == M_DIV)  || (bus.multicycle_type == M_MULT) ||
                         (bus.multicycle_type == M_MADD) || (bus.multicycle_type == M_MSUB);
    assign w_a_mag     = md_mag(bus.a, w_is_signed);
    assign w_b_mag     = md_mag(bus.b, w_is_signed);
    assign w_accept    = (r_state == ST_IDLE) && bus.start && !bus.flush;

    md_iter_core u_core (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_accept),
        .i_step   (r_state == ST_BUSY),
        .i_is_div (w_is_div),
        .i_init   (w_is_div ? w_a_mag : w_b_mag),
        .i_opnd   (w_is_div ? w_b_mag : w_a_mag),
        .o_hi_nxt (w_core_hi),
        .o_lo_nxt (w_core_lo)
    );

    // Sign fix-up on the final step's combinational result, so DONE lands
    // exactly one cycle after the 32nd iteration.
    always_comb begin
        w_prod   = {w_core_hi, w_core_lo};
        if (r_neg_q) begin
            w_prod = ~w_prod + 64'd1;
        end
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = r_neg_r ? (~w_core_hi + 32'd1) : w_core_hi;
                w_res_lo = r_neg_q ? (~w_core_lo + 32'd1) : w_core_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_a      <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (bus.flush) begin
            r_state  <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_is_signed && (bus.a[31] ^ bus.b[31]);
                        r_neg_r  <= w_is_signed && w_is_div && bus.a[31];
                        r_b_zero <= (bus.b == 32'd0);
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hi = r_hi;
    assign bus.lo = r_lo;
    assign bus.ok = reset ? ~bus.start
                          : ((r_state == ST_DONE) || ((r_state == ST_IDLE) && !bus.start));

endmodule

`default_nettype wire

// File: tb/tb_multdiv_engine.sv
// ============================================================================
// Module : tb_multdiv_engine
// Brief  : Directed self-checking bench with a cycle-level reference model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_engine;
    import multdiv_engine_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multdiv_engine_if bus ();

    multdiv_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: m_cyc is the cycle index of the pending instruction
    // (-1 when idle, 33 when its result is presented).
    int          m_cyc   = -1;
    bit          m_valid = 1'b0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;
    multicycle_t m_op    = M_MULTU;
    logic [31:0] m_a     = 32'd0;
    logic [31:0] m_b     = 32'd0;

    function automatic logic [63:0] ref_result(multicycle_t op, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            M_MULTU: res = {32'd0, a} * {32'd0, b};
            M_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            M_DIV: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = sa * sb;
        endcase
        return res;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc   = -1;
            m_hi    = 32'd0;
            m_lo    = 32'd0;
            m_valid = 1'b1;
        end else if (bus.flush) begin
            m_cyc = -1;
        end else if (m_cyc == -1) begin
            if (bus.start) begin
                m_cyc = 1;
                m_op  = bus.multicycle_type;
                m_a   = bus.a;
                m_b   = bus.b;
            end
        end else if (m_cyc == 33) begin
            m_cyc = -1;
        end else begin
            m_cyc++;
            if (m_cyc == 33) {m_hi, m_lo} = ref_result(m_op, m_a, m_b);
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_ok;
        if (m_valid) begin
            exp_ok = reset ? !bus.start : ((m_cyc == 33) || ((m_cyc == -1) && !bus.start));
            check32("cyc_ok", {31'd0, bus.ok}, {31'd0, exp_ok});
            check32("cyc_hi", bus.hi, m_hi);
            check32("cyc_lo", bus.lo, m_lo);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input multicycle_t op, input logic [31:0] a, input logic [31:0] b);
        bus.start           = 1'b1;
        bus.multicycle_type = op;
        bus.a               = a;
        bus.b               = b;
    endtask

    // Counts ok=0 cycles until ok rises; returns sitting at the DONE negedge.
    task automatic wait_ok(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ok === 1'b1) begin
                seen = 1'b1;
                break;
            end
            lat++;
            @(posedge clk);
            #2;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no ok expected ok within 100 cycles");
        end
    endtask

    task automatic run_op(input string name, input multicycle_t op,
                          input logic [31:0] a, input logic [31:0] b);
        int lat;
        drive(op, a, b);
        wait_ok(lat);
        check32({name, "_lat"}, lat, 32'd33);
    endtask

    task automatic release_start;
        tick;
        bus.start = 1'b0;
    endtask

    initial begin
        int lat;
        reset               = 1'b1;
        bus.start           = 1'b0;
        bus.flush           = 1'b0;
        bus.multicycle_type = M_MULTU;
        bus.a               = 32'd0;
        bus.b               = 32'd0;
        repeat (2) tick;
        @(negedge clk);
        check32("rst_hi", bus.hi, 32'd0);
        check32("rst_lo", bus.lo, 32'd0);
        check32("rst_ok", {31'd0, bus.ok}, 32'd1);
        tick;
        reset = 1'b0;
        tick;

        run_op("multu_max", M_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check32("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
        check32("multu_max_lo", bus.lo, 32'h0000_0001);
        release_start;

        run_op("mult_neg", M_MULT, 32'hFFFF_FFFD, 32'd7);
        check32("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check32("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);
        release_start;

        run_op("div_neg", M_DIV, 32'hFFFF_FFF9, 32'd2);
        check32("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check32("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        release_start;

        run_op("divu_z", M_DIVU, 32'd5, 32'd0);
        check32("divu_z_hi", bus.hi, 32'd5);
        check32("divu_z_lo", bus.lo, 32'hFFFF_FFFF);
        release_start;

        // Flush mid-divide, restart on the next cycle with start still held.
        drive(M_DIVU, 32'd100, 32'd7);
        repeat (10) tick;
        bus.flush = 1'b1;
        tick;
        bus.flush = 1'b0;
        @(negedge clk);
        check32("flush_ok", {31'd0, bus.ok}, 32'd0);
        check32("flush_hi", bus.hi, 32'd5);
        check32("flush_lo", bus.lo, 32'hFFFF_FFFF);
        tick;
        wait_ok(lat);
        check32("restart_lat", lat, 32'd32);
        check32("restart_hi", bus.hi, 32'd2);
        check32("restart_lo", bus.lo, 32'd14);
        release_start;

        // Flush beats a simultaneous start in IDLE.
        drive(M_MULTU, 32'd9, 32'd9);
        bus.flush = 1'b1;
        tick;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        tick;

        // Start held through DONE, new operands accepted the very next cycle.
        run_op("b2b_first", M_MULTU, 32'h0001_0000, 32'h0001_0000);
        check32("b2b_first_hi", bus.hi, 32'd1);
        check32("b2b_first_lo", bus.lo, 32'd0);
        tick;
        run_op("b2b_second", M_MULTU, 32'd3, 32'd4);
        check32("b2b_second_hi", bus.hi, 32'd0);
        check32("b2b_second_lo", bus.lo, 32'd12);
        release_start;

        run_op("mult_min", M_MULT, 32'h8000_0000, 32'h8000_0000); release_start;
        run_op("madd", M_MADD, 32'h1234_5678, 32'hFFFF_FFFF);     release_start;
        run_op("msub", M_MSUB, 32'hFFFF_0000, 32'h0001_0003);     release_start;
        run_op("div_pn", M_DIV, 32'd7, 32'hFFFF_FFFE);            release_start;
        run_op("div_ovf", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   release_start;
        run_op("div_z", M_DIV, 32'hFFFF_FFF9, 32'd0);             release_start;
        run_op("divu_big", M_DIVU, 32'hFFFF_FFFF, 32'd10);        release_start;
        run_op("divu_small", M_DIVU, 32'd3, 32'd10);              release_start;

        // Reset in the middle of a signed divide.
        drive(M_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (20) tick;
        reset = 1'b1;
        tick;
        @(negedge clk);
        check32("midrst_hi", bus.hi, 32'd0);
        check32("midrst_lo", bus.lo, 32'd0);
        check32("midrst_ok", {31'd0, bus.ok}, 32'd0);
        tick;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check32("postrst_ok", {31'd0, bus.ok}, 32'd1);
        tick;

        run_op("recover", M_MULTU, 32'd3, 32'd4);
        check32("recover_lo", bus.lo, 32'd12);
        release_start;
        repeat (3) tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
